// File: rtl/npc_ctrl_fsm.sv
// Multi-cycle control sequencer for the NPC core: owns PC and IR, sequences FETCH/DECODE/EXEC/MEM/WB.
// Optional performance counters are enabled by defining NPC_PERF_CNT_EN.
module npc_ctrl_fsm #(
  parameter int unsigned        XLEN          = 32,
  parameter logic [XLEN-1:0]    PC_RESET      = 32'h8000_0000,
  parameter int unsigned        FETCH_TIMEOUT = 1024
) (
  input  logic            clk,
  input  logic            rst,
  output logic            ifu_req,
  input  logic            ifu_valid,
  input  logic [XLEN-1:0] ifu_inst,
  output logic [XLEN-1:0] pc,
  output logic [XLEN-1:0] ir,
  input  logic            dec_is_load,
  input  logic            dec_is_store,
  input  logic            dec_is_ebreak,
  input  logic            dec_rd_wen,
  input  logic [XLEN-1:0] next_pc,
  output logic            lsu_req,
  output logic            lsu_we,
  input  logic            lsu_done,
  output logic            rf_wen,
  output logic            pc_wen,
  output logic            halt,
  output logic            halt_err
`ifdef NPC_PERF_CNT_EN
  ,
  output logic [63:0]     perf_cycle,
  output logic [63:0]     perf_instret
`endif
);

  localparam int unsigned     CNT_W    = $clog2(FETCH_TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FETCH_TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_RESET,
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_MEM,
    S_WB,
    S_HALT
  } state_t;

  state_t           state;
  state_t           state_next;
  logic [CNT_W-1:0] fetch_cnt;
  logic             fetch_hit;
  logic             fetch_expire;

  assign fetch_hit    = (state == S_FETCH) && ifu_valid;
  assign fetch_expire = (state == S_FETCH) && !ifu_valid && (fetch_cnt == CNT_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_RESET;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    ifu_req    = 1'b0;
    lsu_req    = 1'b0;
    lsu_we     = 1'b0;
    rf_wen     = 1'b0;
    pc_wen     = 1'b0;
    halt       = 1'b0;
    case (state)
      S_RESET: begin
        state_next = S_FETCH;
      end
      S_FETCH: begin
        ifu_req = 1'b1;
        // A word arriving in the final allowed cycle still beats the timeout.
        if (ifu_valid) begin
          state_next = S_DECODE;
        end else if (fetch_cnt == CNT_LAST) begin
          state_next = S_HALT;
        end
      end
      S_DECODE: begin
        state_next = dec_is_ebreak ? S_HALT : S_EXEC;
      end
      S_EXEC: begin
        state_next = (dec_is_load || dec_is_store) ? S_MEM : S_WB;
      end
      S_MEM: begin
        lsu_req = 1'b1;
        lsu_we  = dec_is_store;
        if (lsu_done) begin
          state_next = S_WB;
        end
      end
      S_WB: begin
        rf_wen     = dec_rd_wen && !dec_is_store;
        pc_wen     = 1'b1;
        state_next = S_FETCH;
      end
      S_HALT: begin
        halt = 1'b1;
      end
      default: begin
        state_next = S_RESET;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc        <= PC_RESET;
      ir        <= XLEN'(32'h0000_0013);
      fetch_cnt <= '0;
      halt_err  <= 1'b0;
    end else begin
      if (pc_wen) begin
        pc <= next_pc;
      end
      if (fetch_hit || fetch_expire) begin
        fetch_cnt <= '0;
      end else if (state == S_FETCH) begin
        fetch_cnt <= fetch_cnt + CNT_W'(1);
      end
      if (fetch_hit) begin
        ir <= ifu_inst;
      end
      if (fetch_expire) begin
        halt_err <= 1'b1;
      end
    end
  end

`ifdef NPC_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_cycle   <= 64'd0;
      perf_instret <= 64'd0;
    end else begin
      if ((state != S_RESET) && (state != S_HALT)) begin
        perf_cycle <= perf_cycle + 64'd1;
      end
      if (state == S_WB) begin
        perf_instret <= perf_instret + 64'd1;
      end
    end
  end
`else
  // Default build carries no performance counters.
`endif

endmodule

// File: tb/tb_npc_ctrl_fsm.sv
// Directed testbench for npc_ctrl_fsm: per-cycle expected outputs go through a scoreboard queue.
// Built with FETCH_TIMEOUT=8 so the fetch timeout path is reachable quickly.
module tb_npc_ctrl_fsm;

  localparam logic [31:0] PCR = 32'h8000_0000;
  localparam logic [31:0] NOP = 32'h0000_0013;

  // Strobe vector order: {ifu_req, lsu_req, lsu_we, rf_wen, pc_wen, halt, halt_err}
  localparam logic [6:0] IDLE = 7'b0000000;
  localparam logic [6:0] FET  = 7'b1000000;
  localparam logic [6:0] MEMR = 7'b0100000;
  localparam logic [6:0] MEMW = 7'b0110000;
  localparam logic [6:0] WBR  = 7'b0001100;
  localparam logic [6:0] WBN  = 7'b0000100;
  localparam logic [6:0] HLT  = 7'b0000010;
  localparam logic [6:0] HLTE = 7'b0000011;

  // Decoder flag order: {load, store, ebreak, rd_wen}
  localparam logic [3:0] F_ALU  = 4'b0001;
  localparam logic [3:0] F_LD   = 4'b1001;
  localparam logic [3:0] F_ST   = 4'b0101;
  localparam logic [3:0] F_LDST = 4'b1101;
  localparam logic [3:0] F_EB   = 4'b0010;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ifu_req;
  logic        ifu_valid;
  logic [31:0] ifu_inst;
  logic [31:0] pc;
  logic [31:0] ir;
  logic        dec_is_load;
  logic        dec_is_store;
  logic        dec_is_ebreak;
  logic        dec_rd_wen;
  logic [31:0] next_pc;
  logic        lsu_req;
  logic        lsu_we;
  logic        lsu_done;
  logic        rf_wen;
  logic        pc_wen;
  logic        halt;
  logic        halt_err;
`ifdef NPC_PERF_CNT_EN
  logic [63:0] perf_cycle;
  logic [63:0] perf_instret;
`endif

  npc_ctrl_fsm #(
    .XLEN          (32),
    .PC_RESET      (PCR),
    .FETCH_TIMEOUT (8)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .ifu_req       (ifu_req),
    .ifu_valid     (ifu_valid),
    .ifu_inst      (ifu_inst),
    .pc            (pc),
    .ir            (ir),
    .dec_is_load   (dec_is_load),
    .dec_is_store  (dec_is_store),
    .dec_is_ebreak (dec_is_ebreak),
    .dec_rd_wen    (dec_rd_wen),
    .next_pc       (next_pc),
    .lsu_req       (lsu_req),
    .lsu_we        (lsu_we),
    .lsu_done      (lsu_done),
    .rf_wen        (rf_wen),
    .pc_wen        (pc_wen),
    .halt          (halt),
    .halt_err      (halt_err)
`ifdef NPC_PERF_CNT_EN
    ,
    .perf_cycle    (perf_cycle),
    .perf_instret  (perf_instret)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    logic [6:0]  strobes;
    logic [31:0] pc;
    logic [31:0] ir;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  task automatic applyStimulus(input logic valid, input logic [31:0] inst,
                               input logic [3:0] flags, input logic [31:0] npc,
                               input logic done);
    ifu_valid = valid;
    ifu_inst  = inst;
    {dec_is_load, dec_is_store, dec_is_ebreak, dec_rd_wen} = flags;
    next_pc   = npc;
    lsu_done  = done;
  endtask

  task automatic checkOutput();
    exp_t       e;
    logic [6:0] obs;
    if (sb.size() == 0) begin
      errors++;
      $display("[TB] FAIL scoreboard_empty: observed 0 entries, expected 1");
      return;
    end
    e   = sb.pop_front();
    obs = {ifu_req, lsu_req, lsu_we, rf_wen, pc_wen, halt, halt_err};
    checks++;
    assert (obs === e.strobes) else begin
      errors++;
      $error("[TB] FAIL %s strobes: observed %b expected %b", e.tag, obs, e.strobes);
    end
    checks++;
    assert (pc === e.pc) else begin
      errors++;
      $error("[TB] FAIL %s pc: observed %h expected %h", e.tag, pc, e.pc);
    end
    checks++;
    assert (ir === e.ir) else begin
      errors++;
      $error("[TB] FAIL %s ir: observed %h expected %h", e.tag, ir, e.ir);
    end
  endtask

  // Queue this cycle's expectation, sample mid-cycle, then advance one clock.
  task automatic cycleStep(input string tag, input logic [6:0] s,
                           input logic [31:0] p, input logic [31:0] i);
    exp_t e;
    e.tag     = tag;
    e.strobes = s;
    e.pc      = p;
    e.ir      = i;
    sb.push_back(e);
    #1;
    checkOutput();
    @(posedge clk);
    #1;
  endtask

  initial begin
    applyStimulus(1'b0, 32'h0, 4'b0000, 32'h0, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    cycleStep("reset", IDLE, PCR, NOP);

    // addi x1,x0,1
    applyStimulus(1'b1, 32'h0010_0093, F_ALU, 32'h8000_0004, 1'b0);
    cycleStep("addi_F", FET, PCR, NOP);
    applyStimulus(1'b0, 32'h0, F_ALU, 32'h8000_0004, 1'b1);
    cycleStep("addi_D", IDLE, PCR, 32'h0010_0093);
    cycleStep("addi_E", IDLE, PCR, 32'h0010_0093);
    applyStimulus(1'b0, 32'h0, F_ALU, 32'h8000_0004, 1'b0);
    cycleStep("addi_W", WBR, PCR, 32'h0010_0093);

    // load with three MEM cycles; stray ifu_valid in DECODE must not touch ir
    applyStimulus(1'b1, 32'h0000_2083, F_LD, 32'h8000_0008, 1'b0);
    cycleStep("ld_F", FET, 32'h8000_0004, 32'h0010_0093);
    applyStimulus(1'b1, 32'hDEAD_BEEF, F_LD, 32'h8000_0008, 1'b0);
    cycleStep("ld_D", IDLE, 32'h8000_0004, 32'h0000_2083);
    applyStimulus(1'b0, 32'h0, F_LD, 32'h8000_0008, 1'b0);
    cycleStep("ld_E", IDLE, 32'h8000_0004, 32'h0000_2083);
    cycleStep("ld_M1", MEMR, 32'h8000_0004, 32'h0000_2083);
    cycleStep("ld_M2", MEMR, 32'h8000_0004, 32'h0000_2083);
    applyStimulus(1'b0, 32'h0, F_LD, 32'h8000_0008, 1'b1);
    cycleStep("ld_M3", MEMR, 32'h8000_0004, 32'h0000_2083);
    applyStimulus(1'b0, 32'h0, F_LD, 32'h8000_0008, 1'b0);
    cycleStep("ld_W", WBR, 32'h8000_0004, 32'h0000_2083);

    // store with immediate lsu_done
    applyStimulus(1'b1, 32'h0010_2023, F_ST, 32'h8000_000C, 1'b0);
    cycleStep("st_F", FET, 32'h8000_0008, 32'h0000_2083);
    applyStimulus(1'b0, 32'h0, F_ST, 32'h8000_000C, 1'b0);
    cycleStep("st_D", IDLE, 32'h8000_0008, 32'h0010_2023);
    cycleStep("st_E", IDLE, 32'h8000_0008, 32'h0010_2023);
    applyStimulus(1'b0, 32'h0, F_ST, 32'h8000_000C, 1'b1);
    cycleStep("st_M", MEMW, 32'h8000_0008, 32'h0010_2023);
    applyStimulus(1'b0, 32'h0, F_ST, 32'h8000_000C, 1'b0);
    cycleStep("st_W", WBN, 32'h8000_0008, 32'h0010_2023);

    // load and store flags together: store wins
    applyStimulus(1'b1, 32'h0011_2223, F_LDST, 32'h8000_0010, 1'b0);
    cycleStep("ldst_F", FET, 32'h8000_000C, 32'h0010_2023);
    applyStimulus(1'b0, 32'h0, F_LDST, 32'h8000_0010, 1'b0);
    cycleStep("ldst_D", IDLE, 32'h8000_000C, 32'h0011_2223);
    cycleStep("ldst_E", IDLE, 32'h8000_000C, 32'h0011_2223);
    applyStimulus(1'b0, 32'h0, F_LDST, 32'h8000_0010, 1'b1);
    cycleStep("ldst_M", MEMW, 32'h8000_000C, 32'h0011_2223);
    applyStimulus(1'b0, 32'h0, F_LDST, 32'h8000_0010, 1'b0);
    cycleStep("ldst_W", WBN, 32'h8000_000C, 32'h0011_2223);

    // ebreak: sticky halt, pc frozen, stray handshakes ignored
    applyStimulus(1'b1, 32'h0010_0073, F_EB, 32'h1234_5678, 1'b0);
    cycleStep("eb_F", FET, 32'h8000_0010, 32'h0011_2223);
    applyStimulus(1'b0, 32'h0, F_EB, 32'h1234_5678, 1'b0);
    cycleStep("eb_D", IDLE, 32'h8000_0010, 32'h0010_0073);
    for (int k = 0; k < 20; k++) begin
      applyStimulus(k[0], 32'h0000_0093, F_EB, 32'h1234_5678, ~k[0]);
      cycleStep($sformatf("eb_halt%0d", k), HLT, 32'h8000_0010, 32'h0010_0073);
    end
    rst = 1'b1;
    applyStimulus(1'b0, 32'h0, 4'b0000, 32'h0, 1'b0);
    cycleStep("eb_rst_asserted", HLT, 32'h8000_0010, 32'h0010_0073);
    rst = 1'b0;
    cycleStep("eb_after_rst", IDLE, PCR, NOP);

    // fetch timeout: eight FETCH cycles without ifu_valid
    for (int k = 0; k < 8; k++) begin
      cycleStep($sformatf("to_F%0d", k), FET, PCR, NOP);
    end
    cycleStep("to_halt0", HLTE, PCR, NOP);
    cycleStep("to_halt1", HLTE, PCR, NOP);
    rst = 1'b1;
    cycleStep("to_rst_asserted", HLTE, PCR, NOP);
    rst = 1'b0;
    cycleStep("to_after_rst", IDLE, PCR, NOP);

    // ifu_valid in the final allowed FETCH cycle wins over the timeout
    for (int k = 0; k < 7; k++) begin
      cycleStep($sformatf("tv_F%0d", k), FET, PCR, NOP);
    end
    applyStimulus(1'b1, 32'h0010_0093, F_ALU, 32'h8000_0004, 1'b0);
    cycleStep("tv_F7", FET, PCR, NOP);
    applyStimulus(1'b0, 32'h0, F_ALU, 32'h8000_0004, 1'b0);
    cycleStep("tv_D", IDLE, PCR, 32'h0010_0093);
    cycleStep("tv_E", IDLE, PCR, 32'h0010_0093);
    cycleStep("tv_W", WBR, PCR, 32'h0010_0093);

    // rst during MEM wait drops lsu_req; a late lsu_done is ignored
    applyStimulus(1'b1, 32'h0000_2083, F_LD, 32'h8000_0008, 1'b0);
    cycleStep("rm_F", FET, 32'h8000_0004, 32'h0010_0093);
    applyStimulus(1'b0, 32'h0, F_LD, 32'h8000_0008, 1'b0);
    cycleStep("rm_D", IDLE, 32'h8000_0004, 32'h0000_2083);
    cycleStep("rm_E", IDLE, 32'h8000_0004, 32'h0000_2083);
    cycleStep("rm_M1", MEMR, 32'h8000_0004, 32'h0000_2083);
    rst = 1'b1;
    cycleStep("rm_M2_rst", MEMR, 32'h8000_0004, 32'h0000_2083);
    rst = 1'b0;
    applyStimulus(1'b0, 32'h0, F_LD, 32'h8000_0008, 1'b1);
    cycleStep("rm_after_rst", IDLE, PCR, NOP);
    cycleStep("rm_F0_stray_done", FET, PCR, NOP);
    cycleStep("rm_F1_stray_done", FET, PCR, NOP);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
